// File: rtl/cpu_run_ctrl_if.sv
// Bundle of load/dump streams, CPU bus, RAM port and run status around cpu_run_ctrl.
// The slave view belongs to the controller; the master view belongs to its surroundings.
interface cpu_run_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
);
    logic              start_load;
    logic              start_dump;
    logic              load_valid;
    logic [7:0]        load_data;
    logic              load_last;
    logic              load_ready;
    logic              dump_valid;
    logic [7:0]        dump_data;
    logic              dump_last;
    logic              dump_ready;
    logic              cpu_reset;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_rw;
    logic [7:0]        cpu_data_out;
    logic [7:0]        cpu_data_in;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [ADDR_W-1:0] halt_pc;
    logic [CNT_W-1:0]  cycle_count;

    modport slave (
        input  start_load, start_dump, load_valid, load_data, load_last, dump_ready,
        input  cpu_addr, cpu_rw, cpu_data_out, ram_rdata,
        output load_ready, dump_valid, dump_data, dump_last, cpu_reset, cpu_data_in,
        output ram_addr, ram_we, ram_wdata, busy, done, timeout, halt_pc, cycle_count
    );

    modport master (
        output start_load, start_dump, load_valid, load_data, load_last, dump_ready,
        output cpu_addr, cpu_rw, cpu_data_out, ram_rdata,
        input  load_ready, dump_valid, dump_data, dump_last, cpu_reset, cpu_data_in,
        input  ram_addr, ram_we, ram_wdata, busy, done, timeout, halt_pc, cycle_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Load / run / dump sequencer for the accumulator CPU; owns the RAM port and
// decides when the CPU has halted (sustained reads of one address) or timed out.
module cpu_run_ctrl #(
    parameter int          ADDR_W      = 6,
    parameter int          CNT_W       = 16,
    parameter int unsigned MAX_CYCLES  = (2 ** CNT_W) - 1,
    parameter int          HALT_STABLE = 6
) (
    input logic          clk,
    input logic          reset,
    cpu_run_ctrl_if.slave bus
);
    localparam int                ST_W     = $clog2(HALT_STABLE + 1);
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RUN      = 3'd2,
        S_HALTED   = 3'd3,
        S_DUMP_RD  = 3'd4,
        S_DUMP_OUT = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ST_W-1:0]   stable_q, stable_d;
    logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic              timeout_q, timeout_d;
    logic [ADDR_W-1:0] halt_pc_q, halt_pc_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_acc_s;

    assign load_acc_s = (state_q == S_LOAD) && bus.load_valid;

    // Next-state and next-register computation for the whole sequencer.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        stable_d      = '0;
        prev_addr_d   = bus.cpu_addr;
        cycle_count_d = cycle_count_q;
        timeout_d     = timeout_q;
        halt_pc_d     = halt_pc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_load) begin
                    state_d       = S_LOAD;
                    ptr_d         = '0;
                    cycle_count_d = '0;
                    timeout_d     = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (load_acc_s) begin
                    // The pointer saturates at the top address instead of wrapping.
                    if (ptr_q != PTR_LAST) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end else begin
                        ptr_d = ptr_q;
                    end
                    if (bus.load_last || (ptr_q == PTR_LAST)) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_RUN: begin
                cycle_count_d = cycle_count_q + CNT_W'(1);
                if (bus.cpu_rw && (bus.cpu_addr == prev_addr_q)) begin
                    stable_d = stable_q + ST_W'(1);
                end else begin
                    stable_d = '0;
                end
                // A halt detected on the budget's last cycle still counts as a halt.
                if (stable_d == ST_W'(HALT_STABLE)) begin
                    state_d   = S_HALTED;
                    halt_pc_d = bus.cpu_addr;
                    timeout_d = 1'b0;
                end else if (cycle_count_d == CNT_MAX) begin
                    state_d   = S_HALTED;
                    halt_pc_d = bus.cpu_addr;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_HALTED: begin
                if (bus.start_load) begin
                    state_d       = S_LOAD;
                    ptr_d         = '0;
                    cycle_count_d = '0;
                    timeout_d     = 1'b0;
                end else if (bus.start_dump) begin
                    state_d = S_DUMP_RD;
                    ptr_d   = '0;
                end else begin
                    state_d = S_HALTED;
                end
            end
            S_DUMP_RD: begin
                state_d = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (bus.dump_ready) begin
                    if (ptr_q == PTR_LAST) begin
                        state_d = S_HALTED;
                    end else begin
                        state_d = S_DUMP_RD;
                        ptr_d   = ptr_q + ADDR_W'(1);
                    end
                end else begin
                    state_d = S_DUMP_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        cpu_reset_d = (state_d != S_RUN);
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            stable_q      <= '0;
            prev_addr_q   <= '0;
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
            halt_pc_q     <= '0;
            cpu_reset_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            stable_q      <= stable_d;
            prev_addr_q   <= prev_addr_d;
            cycle_count_q <= cycle_count_d;
            timeout_q     <= timeout_d;
            halt_pc_q     <= halt_pc_d;
            cpu_reset_q   <= cpu_reset_d;
        end
    end

    // RAM port ownership: the CPU drives it only while running.
    always_comb begin
        if (state_q == S_RUN) begin
            bus.ram_addr  = bus.cpu_addr;
            bus.ram_we    = ~bus.cpu_rw;
            bus.ram_wdata = bus.cpu_data_out;
        end else begin
            bus.ram_addr  = ptr_q;
            bus.ram_we    = load_acc_s;
            bus.ram_wdata = (state_q == S_LOAD) ? bus.load_data : 8'h00;
        end
    end

    assign bus.load_ready  = (state_q == S_LOAD);
    assign bus.dump_valid  = (state_q == S_DUMP_OUT);
    assign bus.dump_data   = bus.ram_rdata;
    assign bus.dump_last   = (state_q == S_DUMP_OUT) && (ptr_q == PTR_LAST);
    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.cpu_data_in = bus.ram_rdata;
    assign bus.busy        = (state_q == S_LOAD) || (state_q == S_RUN) ||
                             (state_q == S_DUMP_RD) || (state_q == S_DUMP_OUT);
    assign bus.done        = (state_q == S_HALTED) || (state_q == S_DUMP_RD) ||
                             (state_q == S_DUMP_OUT);
    assign bus.timeout     = timeout_q;
    assign bus.halt_pc     = halt_pc_q;
    assign bus.cycle_count = cycle_count_q;
endmodule
